byte_enable_dual_port_ram: RTL and testbench
============================================

BYTE_ENABLE_DUAL_PORT_RAM -- requirements
Module: byte_enable_dual_port_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width in bits; must be a multiple of BYTE_WIDTH.
REQ-002 SHALL have parameter BYTE_WIDTH, default 8: width of one byte-enable lane.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 32: address port width; only the low INDEX_BITS bits are decoded.
REQ-004 SHALL have parameter INDEX_BITS, default 6: RAM_DEPTH = 2**INDEX_BITS words.
REQ-005 SHALL have parameter READ_LATENCY, default 1: legal values 1 or 2 cycles from request to valid.
REQ-006 SHALL have parameter CROSS_PORT, default "OLD_DATA": legal values "OLD_DATA" or "NEW_DATA".
REQ-007 SHALL have parameter CLEAR_ON_RESET, default 1: when 1, the block zero-fills the array after reset.
REQ-008 SHALL have port clock, input, 1 bit: single clock, rising edge.
REQ-009 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have ports req0/req1, input, 1 bit: request strobe for port 0/1.
REQ-011 SHALL have ports we0/we1, input, 1 bit: write when 1, read when 0; ignored unless the matching req is 1.
REQ-012 SHALL have ports be0/be1, input, DATA_WIDTH/BYTE_WIDTH bits: byte-lane write enables.
REQ-013 SHALL have ports address0/address1, input, ADDRESS_WIDTH bits: word address.
REQ-014 SHALL have ports data_in0/data_in1, input, DATA_WIDTH bits: write data.
REQ-015 SHALL have ports data_out0/data_out1, output, DATA_WIDTH bits: read or write-through data.
REQ-016 SHALL have ports valid0/valid1, output, 1 bit: data_outN is valid this cycle.
REQ-017 SHALL have port ready, output, 1 bit: array initialised; requests are accepted.
REQ-018 SHALL have port collision, output, 1 bit: one-cycle pulse flagging a same-address double write.

Function
REQ-019 SHALL implement the init FSM: states CLEAR and READY; reset enters CLEAR if CLEAR_ON_RESET=1, else READY.
REQ-020 SHALL, in CLEAR, write all-zero to index 0..RAM_DEPTH-1 one word per cycle, with ready=0 and all req inputs ignored.
REQ-021 SHALL move CLEAR->READY on the cycle after index RAM_DEPTH-1 is written, with ready=1 from that cycle; clearing takes exactly RAM_DEPTH cycles after reset deasserts.
REQ-022 SHALL accept a request on any cycle with ready=1 and reqN=1; there is no backpressure and one request per port per cycle.
REQ-023 SHALL, on an accepted read, assert validN exactly READ_LATENCY cycles later with data_outN = mem[address].
REQ-024 SHALL, on an accepted write, update only lanes with beN=1, and assert validN READ_LATENCY cycles later with data_outN = the resulting stored word (write-through).
REQ-025 SHALL, when a write has be=0, leave memory unchanged; validN still pulses with the unchanged word.
REQ-026 SHALL, when both ports write the same index in one cycle, give port 1 precedence on overlapping lanes, merge non-overlapping lanes, pulse collision one cycle later, and return the merged word on both data_out ports.
REQ-027 SHALL, for a read on one port and a write on the other to the same index, return the pre-write word with CROSS_PORT="OLD_DATA" and the post-write merged word with "NEW_DATA".
REQ-028 SHALL, with READ_LATENCY=2, add one output register stage so that data and valid advance together; back-to-back requests yield back-to-back valids.
REQ-029 SHALL hold data_outN at its last value when validN=0.
REQ-030 SHALL ignore address bits above INDEX_BITS, so addresses alias modulo RAM_DEPTH.

Reset
REQ-031 SHALL, on reset assertion, immediately clear valid0, valid1, collision, ready, data_out0, data_out1 and all pipeline valids to 0.
REQ-032 SHALL, on reset mid-clear or mid-read, discard in-flight requests and restart the FSM per REQ-019 from index 0.
REQ-033 SHALL not reset the array contents except through the CLEAR sweep.

Structure
REQ-034 SHALL place the FSM state encoding and the CROSS_PORT string constants in the shared cache package.
REQ-035 SHALL use one sub-module, byte_lane_merge, that combines an old word, new data and be into the merged word; it is instantiated per port and once for the collision merge.

Verification
REQ-036 SHALL cover reset release with CLEAR_ON_RESET=1, INDEX_BITS=6 -> ready rises after 64 cycles; a read of address 0x3F returns 0x00000000.
REQ-037 SHALL cover writing 0xAABBCCDD with be0=4'b0101 over 0x11223344 at addr 5, READ_LATENCY=1 -> valid0 is 1 one cycle later, data_out0=0x11BB33DD.
REQ-038 SHALL cover a same-cycle write at addr 9: port0 0x11111111 with be=4'b1111, port1 0x22222222 with be=4'b0011 -> stored 0x11112222 and collision pulses once.
REQ-039 SHALL cover port0 reading addr 7 (holds 0x5) while port1 writes 0x9 there -> data_out0=0x5 with OLD_DATA and 0x9 with NEW_DATA.
REQ-040 SHALL cover READ_LATENCY=2 with reads of 4 addresses issued back-to-back -> 4 consecutive valid0 pulses starting 2 cycles after the first request, in order.
REQ-041 SHALL cover reset asserted mid-clear at index 20 -> ready stays 0 and, after release, the full 64-cycle sweep reruns from index 0.

Source files
------------

// File: rtl/byte_enable_dual_port_ram_pkg.sv
// Shared constants for the byte-enable dual-port RAM: init FSM encoding and cross-port policy names.
// Latency: n/a (constants and a constant helper function only).
// Backpressure: n/a.
package byte_enable_dual_port_ram_pkg;

  // Init FSM: sweep the array to zero, then serve requests.
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Cross-port same-index read policy, as 8-character ASCII strings.
  localparam logic [63:0] CP_OLD_DATA = "OLD_DATA";
  localparam logic [63:0] CP_NEW_DATA = "NEW_DATA";

  // True when a read racing a write on the other port should see the written word.
  function automatic logic is_new_data(input logic [63:0] cross_port);
    return (cross_port == CP_NEW_DATA);
  endfunction

endpackage

// File: rtl/byte_enable_dual_port_ram_byte_lane_merge.sv
// Byte-lane merge: lanes with i_be=1 take i_new, the rest keep i_old.
// Latency: purely combinational.
// Backpressure: none.
module byte_lane_merge #(
  parameter  int DATA_WIDTH = 32,
  parameter  int BYTE_WIDTH = 8,
  localparam int LANES      = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] i_old,
  input  logic [DATA_WIDTH-1:0] i_new,
  input  logic [LANES-1:0]      i_be,
  output logic [DATA_WIDTH-1:0] o_merged
);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign o_merged[g*BYTE_WIDTH +: BYTE_WIDTH] =
      i_be[g] ? i_new[g*BYTE_WIDTH +: BYTE_WIDTH] : i_old[g*BYTE_WIDTH +: BYTE_WIDTH];
  end

endmodule

// File: rtl/byte_enable_dual_port_ram.sv
// Dual-port byte-enable RAM with zero-fill sweep after reset, write-through outputs and collision flag.
// Latency: READ_LATENCY (1 or 2) cycles from accepted request to validN; clear sweep takes RAM_DEPTH cycles.
// Backpressure: none; every request with ready=1 is accepted, requests during the sweep are dropped.
module byte_enable_dual_port_ram
  import byte_enable_dual_port_ram_pkg::*;
#(
  parameter  int          DATA_WIDTH     = 32,
  parameter  int          BYTE_WIDTH     = 8,
  parameter  int          ADDRESS_WIDTH  = 32,
  parameter  int          INDEX_BITS     = 6,
  parameter  int          READ_LATENCY   = 1,
  parameter  logic [63:0] CROSS_PORT     = CP_OLD_DATA,
  parameter  int          CLEAR_ON_RESET = 1,
  localparam int          LANES          = DATA_WIDTH / BYTE_WIDTH,
  localparam int          RAM_DEPTH      = 2 ** INDEX_BITS
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req0,
  input  logic                     req1,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [LANES-1:0]         be0,
  input  logic [LANES-1:0]         be1,
  input  logic [ADDRESS_WIDTH-1:0] address0,
  input  logic [ADDRESS_WIDTH-1:0] address1,
  input  logic [DATA_WIDTH-1:0]    data_in0,
  input  logic [DATA_WIDTH-1:0]    data_in1,
  output logic [DATA_WIDTH-1:0]    data_out0,
  output logic [DATA_WIDTH-1:0]    data_out1,
  output logic                     valid0,
  output logic                     valid1,
  output logic                     ready,
  output logic                     collision
);

  localparam logic NEW_DATA_MODE = is_new_data(CROSS_PORT);

  // Storage and init sweep state. The array itself is never reset: only the sweep zeroes it.
  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
  logic [0:0]            r_state;
  logic [INDEX_BITS-1:0] r_clr_idx;

  // First output stage (the only one when READ_LATENCY=1).
  logic                  r_s1_vld0;
  logic                  r_s1_vld1;
  logic [DATA_WIDTH-1:0] r_s1_dat0;
  logic [DATA_WIDTH-1:0] r_s1_dat1;
  logic                  r_coll;

  // Request decode.
  logic                  w_ready;
  logic [INDEX_BITS-1:0] w_idx0;
  logic [INDEX_BITS-1:0] w_idx1;
  logic                  w_acc0;
  logic                  w_acc1;
  logic                  w_wr0;
  logic                  w_wr1;
  logic                  w_same_idx;
  logic                  w_coll;

  // Data paths.
  logic [DATA_WIDTH-1:0] w_old0;
  logic [DATA_WIDTH-1:0] w_old1;
  logic [DATA_WIDTH-1:0] w_merge0;
  logic [DATA_WIDTH-1:0] w_merge1;
  logic [DATA_WIDTH-1:0] w_merge_coll;
  logic [DATA_WIDTH-1:0] w_res0;
  logic [DATA_WIDTH-1:0] w_res1;

  assign w_ready    = (r_state == ST_READY);
  assign ready      = w_ready;

  // Only the low INDEX_BITS of each address are decoded, so addresses alias modulo RAM_DEPTH.
  assign w_idx0     = address0[INDEX_BITS-1:0];
  assign w_idx1     = address1[INDEX_BITS-1:0];

  assign w_acc0     = w_ready & req0;
  assign w_acc1     = w_ready & req1;
  assign w_wr0      = w_acc0 & we0;
  assign w_wr1      = w_acc1 & we1;
  assign w_same_idx = (w_idx0 == w_idx1);
  assign w_coll     = w_wr0 & w_wr1 & w_same_idx;

  assign w_old0     = r_mem[w_idx0];
  assign w_old1     = r_mem[w_idx1];

  if (ADDRESS_WIDTH > INDEX_BITS) begin : g_addr_hi
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = |{address0[ADDRESS_WIDTH-1:INDEX_BITS],
                                address1[ADDRESS_WIDTH-1:INDEX_BITS]};
  end

  // Per-port merge of the stored word with that port's write data.
  byte_lane_merge #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_merge0 (
    .i_old    (w_old0),
    .i_new    (data_in0),
    .i_be     (be0),
    .o_merged (w_merge0)
  );

  byte_lane_merge #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_merge1 (
    .i_old    (w_old1),
    .i_new    (data_in1),
    .i_be     (be1),
    .o_merged (w_merge1)
  );

  // Double write to one index: layer port 1 over port 0's result so port 1 wins overlapping lanes.
  byte_lane_merge #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_merge_coll (
    .i_old    (w_merge0),
    .i_new    (data_in1),
    .i_be     (be1),
    .o_merged (w_merge_coll)
  );

  // Choose each port's returned word: stored result for writes, old or new word for reads.
  always_comb begin
    w_res0 = w_old0;
    w_res1 = w_old1;
    if (w_wr0) begin
      w_res0 = w_coll ? w_merge_coll : w_merge0;
    end else if (NEW_DATA_MODE && w_wr1 && w_same_idx) begin
      w_res0 = w_merge1;
    end
    if (w_wr1) begin
      w_res1 = w_coll ? w_merge_coll : w_merge1;
    end else if (NEW_DATA_MODE && w_wr0 && w_same_idx) begin
      w_res1 = w_merge0;
    end
  end

  // Init FSM: sweep one index per cycle, then stay READY until the next reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      r_clr_idx <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_clr_idx <= r_clr_idx + INDEX_BITS'(1);
      if (&r_clr_idx) begin
        r_state <= ST_READY;
      end
    end
  end

  // Array update: zero-fill during the sweep, otherwise apply the accepted writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_clr_idx] <= '0;
      end else if (w_coll) begin
        r_mem[w_idx0] <= w_merge_coll;
      end else begin
        if (w_wr0) begin
          r_mem[w_idx0] <= w_merge0;
        end
        if (w_wr1) begin
          r_mem[w_idx1] <= w_merge1;
        end
      end
    end
  end

  // First output stage: capture the returned word on accept, hold it otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1_vld0 <= 1'b0;
      r_s1_vld1 <= 1'b0;
      r_s1_dat0 <= '0;
      r_s1_dat1 <= '0;
      r_coll    <= 1'b0;
    end else begin
      r_s1_vld0 <= w_acc0;
      r_s1_vld1 <= w_acc1;
      r_coll    <= w_coll;
      if (w_acc0) begin
        r_s1_dat0 <= w_res0;
      end
      if (w_acc1) begin
        r_s1_dat1 <= w_res1;
      end
    end
  end

  assign collision = r_coll;

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  r_s2_vld0;
    logic                  r_s2_vld1;
    logic [DATA_WIDTH-1:0] r_s2_dat0;
    logic [DATA_WIDTH-1:0] r_s2_dat1;

    // Second output stage: data and valid advance together, data holds between valids.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_s2_vld0 <= 1'b0;
        r_s2_vld1 <= 1'b0;
        r_s2_dat0 <= '0;
        r_s2_dat1 <= '0;
      end else begin
        r_s2_vld0 <= r_s1_vld0;
        r_s2_vld1 <= r_s1_vld1;
        if (r_s1_vld0) begin
          r_s2_dat0 <= r_s1_dat0;
        end
        if (r_s1_vld1) begin
          r_s2_dat1 <= r_s1_dat1;
        end
      end
    end

    assign valid0    = r_s2_vld0;
    assign valid1    = r_s2_vld1;
    assign data_out0 = r_s2_dat0;
    assign data_out1 = r_s2_dat1;
  end else begin : g_lat1
    assign valid0    = r_s1_vld0;
    assign valid1    = r_s1_vld1;
    assign data_out0 = r_s1_dat0;
    assign data_out1 = r_s1_dat1;
  end

endmodule

// File: tb/tb_byte_enable_dual_port_ram.sv
// Bench for byte_enable_dual_port_ram: one latency-1/OLD_DATA and one latency-2/NEW_DATA instance on shared stimulus.
// Latency: model predicts each instance's outputs per cycle; outputs sampled on the falling edge.
// Backpressure: none; a bounded ready wait and a watchdog keep the run finite.
module tb_byte_enable_dual_port_ram;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 64;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0  = 1'b0;
  logic          req1  = 1'b0;
  logic          we0   = 1'b0;
  logic          we1   = 1'b0;
  logic [3:0]    be0   = '0;
  logic [3:0]    be1   = '0;
  logic [AW-1:0] addr0 = '0;
  logic [AW-1:0] addr1 = '0;
  logic [DW-1:0] din0  = '0;
  logic [DW-1:0] din1  = '0;

  logic [DW-1:0] a_dout0, a_dout1, b_dout0, b_dout1;
  logic          a_vld0, a_vld1, a_rdy, a_coll;
  logic          b_vld0, b_vld1, b_rdy, b_coll;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  byte_enable_dual_port_ram u_ram_a (
    .clock(clock), .reset(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .be0(be0), .be1(be1),
    .address0(addr0), .address1(addr1), .data_in0(din0), .data_in1(din1),
    .data_out0(a_dout0), .data_out1(a_dout1), .valid0(a_vld0), .valid1(a_vld1),
    .ready(a_rdy), .collision(a_coll)
  );

  byte_enable_dual_port_ram #(.READ_LATENCY(2), .CROSS_PORT("NEW_DATA")) u_ram_b (
    .clock(clock), .reset(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .be0(be0), .be1(be1),
    .address0(addr0), .address1(addr1), .data_in0(din0), .data_in1(din1),
    .data_out0(b_dout0), .data_out1(b_dout1), .valid0(b_vld0), .valid1(b_vld1),
    .ready(b_rdy), .collision(b_coll)
  );

  // ---------------- behavioural model ----------------
  logic [DW-1:0] mem [DEPTH];
  int            clr_cnt = 0;
  logic          e_rdy = 1'b0, e_coll = 1'b0;
  logic          ea_vld0 = 1'b0, ea_vld1 = 1'b0;
  logic [DW-1:0] ea_dat0 = '0, ea_dat1 = '0;
  logic          eb1_vld0 = 1'b0, eb1_vld1 = 1'b0;
  logic [DW-1:0] eb1_dat0 = '0, eb1_dat1 = '0;
  logic          eb_vld0 = 1'b0, eb_vld1 = 1'b0;
  logic [DW-1:0] eb_dat0 = '0, eb_dat1 = '0;

  function automatic logic [DW-1:0] apply_be(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                             input logic [3:0] be);
    logic [DW-1:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8 * b));
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  task automatic model_reset();
    clr_cnt = 0;
    e_rdy = 1'b0; e_coll = 1'b0;
    ea_vld0 = 1'b0; ea_vld1 = 1'b0; ea_dat0 = '0; ea_dat1 = '0;
    eb1_vld0 = 1'b0; eb1_vld1 = 1'b0; eb1_dat0 = '0; eb1_dat1 = '0;
    eb_vld0 = 1'b0; eb_vld1 = 1'b0; eb_dat0 = '0; eb_dat1 = '0;
  endtask

  task automatic model_step();
    logic          rdy_before, a0, a1, w0, w1;
    int            i0, i1;
    logic [DW-1:0] pre0, pre1, post0, post1;
    rdy_before = (clr_cnt == DEPTH);
    a0 = rdy_before && req0;
    a1 = rdy_before && req1;
    w0 = a0 && we0;
    w1 = a1 && we1;
    i0 = int'(addr0 % DEPTH);
    i1 = int'(addr1 % DEPTH);
    // latency-2 instance: previous cycle's results move to the outputs
    eb_vld0 = eb1_vld0; if (eb1_vld0) eb_dat0 = eb1_dat0;
    eb_vld1 = eb1_vld1; if (eb1_vld1) eb_dat1 = eb1_dat1;
    if (clr_cnt < DEPTH) begin
      clr_cnt++;
      if (clr_cnt == DEPTH) for (int k = 0; k < DEPTH; k++) mem[k] = '0;
    end
    e_rdy = (clr_cnt == DEPTH);
    pre0 = mem[i0];
    pre1 = mem[i1];
    if (w0) mem[i0] = apply_be(mem[i0], din0, be0);
    if (w1) mem[i1] = apply_be(mem[i1], din1, be1);
    post0 = mem[i0];
    post1 = mem[i1];
    ea_vld0 = a0; if (a0) ea_dat0 = w0 ? post0 : pre0;
    ea_vld1 = a1; if (a1) ea_dat1 = w1 ? post1 : pre1;
    eb1_vld0 = a0; if (a0) eb1_dat0 = post0;
    eb1_vld1 = a1; if (a1) eb1_dat1 = post1;
    e_coll = w0 && w1 && (i0 == i1);
  endtask

  initial begin
    forever begin
      @(posedge clock or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      chk("a_ready", 32'(a_rdy), 32'(e_rdy));
      chk("b_ready", 32'(b_rdy), 32'(e_rdy));
      chk("a_coll", 32'(a_coll), 32'(e_coll));
      chk("b_coll", 32'(b_coll), 32'(e_coll));
      chk("a_valid0", 32'(a_vld0), 32'(ea_vld0));
      chk("a_valid1", 32'(a_vld1), 32'(ea_vld1));
      chk("a_data0", a_dout0, ea_dat0);
      chk("a_data1", a_dout1, ea_dat1);
      chk("b_valid0", 32'(b_vld0), 32'(eb_vld0));
      chk("b_valid1", 32'(b_vld1), 32'(eb_vld1));
      chk("b_data0", b_dout0, eb_dat0);
      chk("b_data1", b_dout1, eb_dat1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic q0, input logic w0, input logic [3:0] b0, input logic [AW-1:0] a0,
                     input logic [DW-1:0] d0, input logic q1, input logic w1, input logic [3:0] b1,
                     input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0 = q0; we0 = w0; be0 = b0; addr0 = a0; din0 = d0;
    req1 = q1; we1 = w1; be1 = b1; addr1 = a1; din1 = d1;
    @(negedge clock);
  endtask

  task automatic idle();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    @(negedge clock);
  endtask

  // Called just after reset release; counts falling edges until ready, bounded.
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!a_rdy && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk(name, 32'(n), 32'd64);
    chk({name, "_b"}, 32'(b_rdy), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_ready", 32'(a_rdy), 32'd0);
    chk("rst_valid0", 32'(a_vld0), 32'd0);
    chk("rst_data0", a_dout0, 32'h0);
    #1 rst_n = 1'b1;
    wait_ready("clear_cycles");

    // read of the last index after the sweep
    cyc(1, 0, 4'h0, 32'h3F, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("rd3f_valid", 32'(a_vld0), 32'd1);
    chk("rd3f_data", a_dout0, 32'h0000_0000);
    idle();

    // partial byte-enable write-through
    cyc(1, 1, 4'hF, 32'h5, 32'h1122_3344, 0, 0, 4'h0, 32'h0, 32'h0);
    idle();
    cyc(1, 1, 4'b0101, 32'h5, 32'hAABB_CCDD, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("be_valid", 32'(a_vld0), 32'd1);
    chk("be_data", a_dout0, 32'h11BB_33DD);
    idle();
    chk("be_lat2_valid", 32'(b_vld0), 32'd1);
    chk("be_lat2_data", b_dout0, 32'h11BB_33DD);

    // address aliasing on port 1
    cyc(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'h0, 32'hFFFF_FF05, 32'h0);
    chk("alias_data", a_dout1, 32'h11BB_33DD);
    idle();

    // be=0 write leaves memory alone but still returns the word
    cyc(1, 1, 4'h0, 32'h5, 32'hFFFF_FFFF, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("be0_valid", 32'(a_vld0), 32'd1);
    chk("be0_data", a_dout0, 32'h11BB_33DD);
    idle();

    // same-index double write
    cyc(1, 1, 4'hF, 32'h9, 32'h1111_1111, 1, 1, 4'b0011, 32'h9, 32'h2222_2222);
    chk("coll_pulse", 32'(a_coll), 32'd1);
    chk("coll_data0", a_dout0, 32'h1111_2222);
    chk("coll_data1", a_dout1, 32'h1111_2222);
    idle();
    chk("coll_drop", 32'(a_coll), 32'd0);
    cyc(1, 0, 4'h0, 32'h9, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("coll_stored", a_dout0, 32'h1111_2222);
    idle();

    // cross-port read/write to one index
    cyc(1, 1, 4'hF, 32'h7, 32'h5, 0, 0, 4'h0, 32'h0, 32'h0);
    idle();
    cyc(1, 0, 4'h0, 32'h7, 32'h0, 1, 1, 4'hF, 32'h7, 32'h9);
    chk("xport_old", a_dout0, 32'h5);
    idle();
    chk("xport_new_valid", 32'(b_vld0), 32'd1);
    chk("xport_new", b_dout0, 32'h9);

    // back-to-back reads through the latency-2 instance
    for (int i = 0; i < 4; i++) cyc(0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 4'hF, 32'(10 + i), 32'hC0DE_0010 + 32'(i));
    idle();
    idle();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 4'h0, 32'(10 + i), 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
      chk("b2b_lat1", a_dout0, 32'hC0DE_0010 + 32'(i));
      if (i == 0) chk("b2b_first_idle", 32'(b_vld0), 32'd0);
      else chk("b2b_data", b_dout0, 32'hC0DE_0010 + 32'(i - 1));
    end
    idle();
    chk("b2b_last_valid", 32'(b_vld0), 32'd1);
    chk("b2b_last_data", b_dout0, 32'hC0DE_0013);
    idle();
    chk("b2b_end_valid", 32'(b_vld0), 32'd0);
    chk("b2b_hold", b_dout0, 32'hC0DE_0013);

    // reset mid-sweep with requests pending, then a full re-sweep
    #1 rst_n = 1'b0;
    @(negedge clock);
    #1 rst_n = 1'b1;
    req0 = 1'b1; we0 = 1'b1; be0 = 4'hF; addr0 = 32'h3F; din0 = 32'hFFFF_FFFF;
    req1 = 1'b1; we1 = 1'b1; be1 = 4'hF; addr1 = 32'h9;  din1 = 32'hFFFF_FFFF;
    repeat (20) @(negedge clock);
    chk("midclr_ready", 32'(a_rdy), 32'd0);
    #1 rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    @(negedge clock);
    chk("midclr_rst_ready", 32'(a_rdy), 32'd0);
    chk("midclr_rst_data", a_dout0, 32'h0);
    #1 rst_n = 1'b1;
    wait_ready("reclear_cycles");
    cyc(1, 0, 4'h0, 32'h3F, 32'h0, 1, 0, 4'h0, 32'h9, 32'h0);
    chk("reclear_3f", a_dout0, 32'h0);
    chk("reclear_9", a_dout1, 32'h0);
    idle();
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
